// File: rtl/loader_pkg.sv
// Shared types and defaults for the switch-driven instruction loader.
// Holds the loader FSM state type and the default word/address geometry.
package loader_pkg;

  localparam int INST_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam logic [15:0] END_WORD_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HI,
    WAIT_LO,
    WRITE,
    DONE
  } loader_state_e;

endpackage

// File: rtl/inst_loader_if.sv
// Instruction memory write port shared between the loader and Inst_Mem.
// The master drives the write strobe, address and data; the memory is the slave.
interface inst_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 16
);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [INST_WIDTH-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, run-length debounce, rising-edge pulse.
// pulse_out is a registered one-cycle strobe when the debounced level goes 0 -> 1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse_out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       syncQ;
  logic             stableLvl;
  logic [CNT_W-1:0] runCnt;

  // runCnt counts consecutive synchronized samples that disagree with the
  // accepted level; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncQ     <= '0;
      stableLvl <= 1'b0;
      runCnt    <= '0;
      pulse_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // which is what makes the synchronizer chain an actual two-stage shift.
      syncQ     <= {syncQ[0], btn_in};
      pulse_out <= 1'b0;
      if (syncQ[1] == stableLvl) begin
        runCnt <= '0;
      end else if (runCnt == LAST_RUN) begin
        runCnt    <= '0;
        stableLvl <= syncQ[1];
        pulse_out <= syncQ[1];
      end else begin
        runCnt <= runCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Loads instruction words byte-by-byte from switches into Inst_Mem, holding the
// processor in reset while a load is in progress.
module inst_loader
  import loader_pkg::*;
#(
  parameter int INST_WIDTH      = INST_WIDTH_DEF,
  parameter int SWITCH_WIDTH    = 8,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter logic [INST_WIDTH-1:0] END_WORD = INST_WIDTH'(END_WORD_DEF)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic                    byte_btn,
  input  logic [SWITCH_WIDTH-1:0] sw,
  input  logic                    cpu_rst_req,
  inst_loader_if.master           mem,
  output logic                    cpu_hold,
  output logic                    cpu_rst,
  output logic [ADDR_WIDTH:0]     word_count,
  output logic                    done
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [1:0]              rstSync;
  logic                    rstInt;
  logic                    byteStrobe;
  loader_state_e           state;
  logic [SWITCH_WIDTH-1:0] hiByte;
  logic [INST_WIDTH-1:0]   asmWord;
  logic                    endSeen;

  // NOTE: assertion reaches every flop asynchronously, but release is re-timed
  // through two flops so no state leaves reset on a partial clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rstSync <= '0;
    else        rstSync <= {rstSync[0], 1'b1};
  end
  assign rstInt = rstSync[1];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .reset    (rstInt),
    .btn_in   (byte_btn),
    .pulse_out(byteStrobe)
  );

  assign asmWord = INST_WIDTH'({hiByte, sw});

  // Outputs are registered alongside the state so wr_en, cpu_hold and done
  // change only on clock edges and never glitch.
  always_ff @(posedge clk or negedge rstInt) begin
    if (!rstInt) begin
      state       <= IDLE;
      mem.wr_en   <= 1'b0;
      mem.wr_addr <= '0;
      mem.wr_data <= '0;
      cpu_hold    <= 1'b0;
      word_count  <= '0;
      done        <= 1'b0;
      hiByte      <= '0;
      endSeen     <= 1'b0;
    end else begin
      mem.wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_en) begin
            state      <= WAIT_HI;
            word_count <= '0;
            cpu_hold   <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (!load_en) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end else if (byteStrobe) begin
            hiByte <= sw;
            state  <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!load_en) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end else if (byteStrobe) begin
            // The write strobe is staged here so it is high during WRITE,
            // exactly one cycle after the low-byte strobe.
            state   <= WRITE;
            endSeen <= (asmWord == END_WORD);
            if (asmWord != END_WORD) begin
              mem.wr_en   <= 1'b1;
              mem.wr_addr <= word_count[ADDR_WIDTH-1:0];
              mem.wr_data <= asmWord;
              word_count  <= word_count + (ADDR_WIDTH + 1)'(1);
            end
          end
        end
        WRITE: begin
          if (!load_en) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end else if (endSeen || word_count == FULL_COUNT) begin
            state    <= DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            state <= WAIT_HI;
          end
        end
        DONE: begin
          if (!load_en) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cpu_hold <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_rst = cpu_rst_req | cpu_hold;

endmodule
